control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Multi-cycle control FSM for the prototype processor; sequences the gate-level datapath
//  (PC, IR, register file, ALU, memory port) through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
//  Drives all datapath strobes and the memory request handshake; sits between top-level
//  wrapper and the datapath, one instance per core.
// PARAMETERS
//  OPCODE_W     4    opcode field width (values below assume 4)
//  TIMEOUT_W    4    width of memory-wait counter
//  MEM_TIMEOUT  12   wait cycles with Mem_Req=1, Mem_Ready=0 before FAULT; 1..2**TIMEOUT_W-1
// PORTS
//  Clock        in   1   single clock, all state on rising edge
//  Reset        in   1   synchronous, active-high
//  Run          in   1   1 = execute; sampled at instruction boundary only
//  Opcode       in   OPCODE_W  IR opcode field, valid from DECODE onward
//  Alu_Zero     in   1   ALU zero flag, sampled in EXECUTE for BEQZ
//  Mem_Ready    in   1   memory completes current request this cycle
//  Mem_Req      out  1   memory request, held until Mem_Ready
//  Mem_We       out  1   write qualifier for Mem_Req (STORE only)
//  Pc_Inc       out  1   PC <= PC+1
//  Pc_Load      out  1   PC <= branch/jump target
//  Ir_Load      out  1   IR <= memory data
//  Reg_We       out  1   register file write
//  Alu_Op       out  3   0 ADD,1 SUB,2 AND,3 NAND,4 PASS_B
//  State        out  3   current state encoding (debug)
//  Halted       out  1   in HALT
//  Fault        out  1   in FAULT
//  Illegal_Op   out  1   one-cycle pulse on undefined opcode
// BEHAVIOUR
//  States: IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MEMORY=4 WRITEBACK=5 HALT=6 FAULT=7.
//  Reset: State=IDLE, all outputs 0, wait counter 0; Reset wins over every other event.
//  IDLE: Run=1 -> FETCH next cycle; else stay.
//  FETCH: Mem_Req=1,Mem_We=0; Mem_Ready=1 -> Ir_Load=1,Pc_Inc=1 same cycle, -> DECODE.
//  DECODE: Alu_Op set from Opcode. 0 NOP -> FETCH/IDLE boundary; F HALT -> HALT;
//   1-4 ADD/SUB/AND/NAND, 5 LOAD, 6 STORE, 7 BEQZ, 8 JMP -> EXECUTE;
//   9-E illegal -> Illegal_Op=1 for this cycle, treated as NOP.
//  EXECUTE: ALU ops -> WRITEBACK; LOAD/STORE (Alu_Op=ADD for address) -> MEMORY;
//   JMP: Pc_Load=1; BEQZ: Pc_Load=Alu_Zero; both -> boundary.
//  MEMORY: Mem_Req=1, Mem_We=(STORE); Mem_Ready=1 -> LOAD: WRITEBACK, STORE: boundary.
//  WRITEBACK: Reg_We=1 (Alu_Op=PASS_B for LOAD), -> boundary.
//  Boundary: Run=1 -> FETCH, Run=0 -> IDLE. Run drop mid-instruction completes it first.
//  Latency (Mem_Ready immediate): NOP 2, BEQZ/JMP 3, ALU 4, STORE 4, LOAD 5 cycles.
//  Wait counter: cleared on entry to FETCH/MEMORY; increments each cycle Mem_Req=1 and
//   Mem_Ready=0; saturates; reaching MEM_TIMEOUT -> FAULT next cycle. Mem_Ready in the
//   same cycle as the limit wins (normal completion).
//  HALT/FAULT: all strobes 0, Mem_Req=0; sticky until Reset (Run ignored).
//  Strobes combinational from State, Opcode, Alu_Zero, Mem_Ready; State registered.
// CONFIGURATION
//  SEQ_SINGLE_STEP_EN defined: adds input Step (1 bit); at each boundary with Run=1 the
//   FSM enters FETCH only on a cycle with Step=1, else waits in IDLE; one instruction
//   per Step pulse. Undefined: no Step port, boundary behaviour as above.
// STRUCTURE
//  Package ctrl_pkg: state encoding constants, opcode constants, Alu_Op encoding,
//   OPCODE_W default; shared with datapath decoder and bench.
//  Sub-module mem_wait_timer: clear/enable/limit counter, outputs Expired; rest is one
//   FSM process plus a combinational output decoder.
// TESTING
//  Reset held 2 cycles, Run=1, Opcode=1, Mem_Ready=1 -> FETCH,DECODE,EXECUTE,WRITEBACK,
//   Reg_We=1 in cycle 4 only, Alu_Op=0, back to FETCH.
//  LOAD with Mem_Ready delayed 3 cycles in MEMORY -> Mem_Req high 4 cycles, no FAULT,
//   WRITEBACK with Alu_Op=4, Reg_We=1.
//  Mem_Ready held 0 in FETCH -> after 12 wait cycles State=7, Fault=1, all strobes 0
//   until Reset; Reset returns State=0.
//  BEQZ with Alu_Zero=1 -> Pc_Load=1 in EXECUTE; Alu_Zero=0 -> Pc_Load=0; Opcode=A ->
//   Illegal_Op one pulse, no Reg_We, next FETCH.
//  Opcode=F -> Halted=1, Run toggling ignored; Run dropped during STORE MEMORY wait ->
//   STORE completes (Mem_We=1 until Mem_Ready), then IDLE.
//  SEQ_SINGLE_STEP_EN build: Run=1, Step pulsed twice -> exactly two instructions retire.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the prototype processor control path.
// Contents: state encoding, opcode constants, ALU operation encoding,
// default opcode width and the opcode -> ALU operation helper.
// Used by control_sequencer, the datapath decoder and the bench.
package ctrl_pkg;

  localparam int unsigned DEF_OPCODE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6,
    ST_FAULT     = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_NAND   = 3'd3,
    ALU_PASS_B = 3'd4
  } alu_op_e;

  localparam logic [DEF_OPCODE_W-1:0] OP_NOP   = 4'h0;
  localparam logic [DEF_OPCODE_W-1:0] OP_ADD   = 4'h1;
  localparam logic [DEF_OPCODE_W-1:0] OP_SUB   = 4'h2;
  localparam logic [DEF_OPCODE_W-1:0] OP_AND   = 4'h3;
  localparam logic [DEF_OPCODE_W-1:0] OP_NAND  = 4'h4;
  localparam logic [DEF_OPCODE_W-1:0] OP_LOAD  = 4'h5;
  localparam logic [DEF_OPCODE_W-1:0] OP_STORE = 4'h6;
  localparam logic [DEF_OPCODE_W-1:0] OP_BEQZ  = 4'h7;
  localparam logic [DEF_OPCODE_W-1:0] OP_JMP   = 4'h8;
  localparam logic [DEF_OPCODE_W-1:0] OP_HALT  = 4'hF;

  // ALU operation implied by an opcode; LOAD/STORE use ADD for address generation.
  function automatic alu_op_e alu_for_opcode(input logic [DEF_OPCODE_W-1:0] op);
    alu_op_e a;
    a = ALU_ADD;
    case (op)
      OP_SUB:          a = ALU_SUB;
      OP_AND:          a = ALU_AND;
      OP_NAND:         a = ALU_NAND;
      OP_BEQZ, OP_JMP: a = ALU_PASS_B;
      default:         a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting on the memory port.
// Ports:
//   Clock   in  clock, rising edge
//   Reset   in  synchronous active-high reset, clears the count
//   Clear   in  clear the count next cycle (has priority over Enable)
//   Enable  in  a wait cycle (request outstanding, memory not ready)
//   Expired out this wait cycle brings the count to LIMIT
module mem_wait_timer #(
  parameter int unsigned W     = 4,
  parameter int unsigned LIMIT = 12
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  input  logic Enable,
  output logic Expired
);

  logic [W-1:0] count;

  // Saturating wait counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count <= '0;
    end else if (Clear) begin
      count <= '0;
    end else if (Enable && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  // Only a genuine wait cycle can expire, so a ready memory always wins.
  assign Expired = Enable && (count >= W'(LIMIT - 1));

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control FSM sequencing the datapath through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, with HALT and FAULT as sticky states.
// Optional build macro: SEQ_SINGLE_STEP_EN adds input Step; an instruction
// starts only on a boundary cycle with Run=1 and Step=1.
// Ports:
//   Clock, Reset        clock and synchronous active-high reset
//   Run                 execute enable, sampled at instruction boundaries
//   Step                single-step pulse (SEQ_SINGLE_STEP_EN only)
//   Opcode              IR opcode field, valid from DECODE onward
//   Alu_Zero            ALU zero flag, used by BEQZ in EXECUTE
//   Mem_Ready           memory completes the current request this cycle
//   Mem_Req, Mem_We     memory request and write qualifier
//   Pc_Inc, Pc_Load     PC increment / load target
//   Ir_Load, Reg_We     IR load / register file write
//   Alu_Op              ALU operation select
//   State               current state (debug)
//   Halted, Fault       in HALT / in FAULT
//   Illegal_Op          pulse on an undefined opcode in DECODE
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W    = DEF_OPCODE_W,
  parameter int unsigned TIMEOUT_W   = 4,
  parameter int unsigned MEM_TIMEOUT = 12
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                Step,
`endif
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Alu_Zero,
  input  logic                Mem_Ready,
  output logic                Mem_Req,
  output logic                Mem_We,
  output logic                Pc_Inc,
  output logic                Pc_Load,
  output logic                Ir_Load,
  output logic                Reg_We,
  output logic [2:0]          Alu_Op,
  output logic [2:0]          State,
  output logic                Halted,
  output logic                Fault,
  output logic                Illegal_Op
);

  state_e                  state;
  state_e                  state_nxt;
  state_e                  boundary;
  logic [DEF_OPCODE_W-1:0] op;
  logic                    go;
  logic                    illegal;
  logic                    mem_phase;
  logic                    expired;

  assign op        = DEF_OPCODE_W'(Opcode);
  assign illegal   = (op >= 4'h9) && (op <= 4'hE);
  assign mem_phase = (state == ST_FETCH) || (state == ST_MEMORY);

`ifdef SEQ_SINGLE_STEP_EN
  assign go = Run && Step;
`else
  assign go = Run;
`endif

  // Where an instruction boundary leads.
  assign boundary = go ? ST_FETCH : ST_IDLE;

  // Cleared whenever no request is outstanding or one completes, so every
  // entry into FETCH/MEMORY starts from zero.
  mem_wait_timer #(
    .W     (TIMEOUT_W),
    .LIMIT (MEM_TIMEOUT)
  ) u_timer (
    .Clock   (Clock),
    .Reset   (Reset),
    .Clear   (!mem_phase || Mem_Ready),
    .Enable  (mem_phase && !Mem_Ready),
    .Expired (expired)
  );

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and datapath strobes.
  always_comb begin
    state_nxt  = state;
    Mem_Req    = 1'b0;
    Mem_We     = 1'b0;
    Pc_Inc     = 1'b0;
    Pc_Load    = 1'b0;
    Ir_Load    = 1'b0;
    Reg_We     = 1'b0;
    Alu_Op     = ALU_ADD;
    Illegal_Op = 1'b0;
    case (state)
      ST_IDLE: state_nxt = boundary;
      ST_FETCH: begin
        Mem_Req = 1'b1;
        if (Mem_Ready) begin
          Ir_Load   = 1'b1;
          Pc_Inc    = 1'b1;
          state_nxt = ST_DECODE;
        end else if (expired) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_DECODE: begin
        Alu_Op = alu_for_opcode(op);
        if (op == OP_HALT) begin
          state_nxt = ST_HALT;
        end else if (op == OP_NOP) begin
          state_nxt = boundary;
        end else if (illegal) begin
          Illegal_Op = 1'b1;
          state_nxt  = boundary;
        end else begin
          state_nxt = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        Alu_Op = alu_for_opcode(op);
        if ((op == OP_LOAD) || (op == OP_STORE)) begin
          state_nxt = ST_MEMORY;
        end else if (op == OP_JMP) begin
          Pc_Load   = 1'b1;
          state_nxt = boundary;
        end else if (op == OP_BEQZ) begin
          Pc_Load   = Alu_Zero;
          state_nxt = boundary;
        end else begin
          state_nxt = ST_WRITEBACK;
        end
      end
      ST_MEMORY: begin
        Mem_Req = 1'b1;
        Mem_We  = (op == OP_STORE);
        if (Mem_Ready) begin
          state_nxt = (op == OP_STORE) ? boundary : ST_WRITEBACK;
        end else if (expired) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_WRITEBACK: begin
        Reg_We    = 1'b1;
        Alu_Op    = (op == OP_LOAD) ? ALU_PASS_B : alu_for_opcode(op);
        state_nxt = boundary;
      end
      ST_HALT:  state_nxt = ST_HALT;
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign State  = state;
  assign Halted = (state == ST_HALT);
  assign Fault  = (state == ST_FAULT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized instruction streams checked cycle by cycle
// against an instruction-level reference that expands each instruction into
// its expected cycle sequence from the latency and handshake rules.
module tb_control_sequencer;

  localparam int unsigned MEM_TIMEOUT = 12;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3,
                         S_MEMORY = 3'd4, S_WRITEBACK = 3'd5, S_HALT = 3'd6, S_FAULT = 3'd7;
`ifdef SEQ_SINGLE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset, Run, Step, Alu_Zero, Mem_Ready;
  logic [3:0] Opcode;
  logic       Mem_Req, Mem_We, Pc_Inc, Pc_Load, Ir_Load, Reg_We, Halted, Fault, Illegal_Op;
  logic [2:0] Alu_Op, State;

  always #5 Clock = ~Clock;

  control_sequencer dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Run        (Run),
`ifdef SEQ_SINGLE_STEP_EN
    .Step       (Step),
`endif
    .Opcode     (Opcode),
    .Alu_Zero   (Alu_Zero),
    .Mem_Ready  (Mem_Ready),
    .Mem_Req    (Mem_Req),
    .Mem_We     (Mem_We),
    .Pc_Inc     (Pc_Inc),
    .Pc_Load    (Pc_Load),
    .Ir_Load    (Ir_Load),
    .Reg_We     (Reg_We),
    .Alu_Op     (Alu_Op),
    .State      (State),
    .Halted     (Halted),
    .Fault      (Fault),
    .Illegal_Op (Illegal_Op)
  );

  // One expected cycle: inputs to drive plus outputs required.
  typedef struct {
    logic [2:0] st;
    logic [3:0] op;
    logic       run, step, rdy, zero;
    logic       req, we, inc, pld, ir, rwe, ill;
    logic       alu_chk;
    logic [2:0] alu;
  } cyc_t;

  cyc_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic cyc_t mk(input logic [2:0] st, input logic [3:0] op);
    cyc_t c;
    c.st = st; c.op = op;
    c.run = 1'($urandom); c.step = 1'($urandom); c.rdy = 1'($urandom); c.zero = 1'($urandom);
    c.req = 0; c.we = 0; c.inc = 0; c.pld = 0; c.ir = 0; c.rwe = 0; c.ill = 0;
    c.alu_chk = 0; c.alu = 3'd0;
    return c;
  endfunction

  // Mostly short waits, occasionally around the timeout limit.
  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 39));
    return (r < 36) ? (r % 4) : int'($urandom_range(10, 13));
  endfunction

  // A few cycles in a sticky state with arbitrary inputs.
  task automatic push_tail(input logic [2:0] st);
    int n;
    n = int'($urandom_range(2, 5));
    for (int i = 0; i < n; i++) q.push_back(mk(st, 4'($urandom)));
  endtask

  // IDLE cycles that do not start an instruction, then one that does.
  task automatic push_idle();
    cyc_t c;
    int   k;
    k = int'($urandom_range(0, 3));
    for (int i = 0; i < k; i++) begin
      c = mk(S_IDLE, 4'($urandom));
      if (STEP_EN && !(c.run && c.step)) begin
        c.run = c.run;
      end else if (STEP_EN) begin
        c.step = 1'b0;
      end else begin
        c.run = 1'b0;
      end
      q.push_back(c);
    end
    c = mk(S_IDLE, 4'($urandom));
    c.run = 1'b1; c.step = 1'b1;
    q.push_back(c);
  endtask

  // w wait cycles then a ready cycle; waits reaching the limit end in FAULT.
  task automatic push_mem_phase(input logic [2:0] st, input logic [3:0] op, input int w,
                                input logic we, output bit ok);
    cyc_t c;
    for (int i = 0; i < w && i < int'(MEM_TIMEOUT); i++) begin
      c = mk(st, op);
      c.rdy = 1'b0; c.req = 1'b1; c.we = we;
      q.push_back(c);
    end
    ok = (w < int'(MEM_TIMEOUT));
    if (ok) begin
      c = mk(st, op);
      c.rdy = 1'b1; c.req = 1'b1; c.we = we;
      if (st == S_FETCH) begin c.ir = 1'b1; c.inc = 1'b1; end
      q.push_back(c);
    end
  endtask

  task automatic plan_instr(output bit term);
    cyc_t       c;
    bit         ok;
    logic [3:0] op;
    logic       arith, mem_op;
    op     = 4'($urandom_range(0, 15));
    arith  = (op >= 4'd1) && (op <= 4'd4);
    mem_op = (op == 4'd5) || (op == 4'd6);
    term   = 1'b0;
    push_mem_phase(S_FETCH, 4'($urandom), pick_wait(), 1'b0, ok);
    if (!ok) begin push_tail(S_FAULT); term = 1'b1; return; end
    c = mk(S_DECODE, op);
    c.ill = (op >= 4'd9) && (op <= 4'd14);
    c.alu_chk = arith || mem_op;
    c.alu = arith ? 3'(op - 4'd1) : 3'd0;
    q.push_back(c);
    if (op == 4'hF) begin push_tail(S_HALT); term = 1'b1; return; end
    if (op == 4'd0 || c.ill) begin
      // boundary after DECODE
    end else begin
      c = mk(S_EXECUTE, op);
      c.alu_chk = arith || mem_op;
      c.alu = arith ? 3'(op - 4'd1) : 3'd0;
      if (op == 4'd8) c.pld = 1'b1;
      if (op == 4'd7) c.pld = c.zero;
      q.push_back(c);
      if (mem_op) begin
        push_mem_phase(S_MEMORY, op, pick_wait(), op == 4'd6, ok);
        if (!ok) begin push_tail(S_FAULT); term = 1'b1; return; end
      end
      if (arith || op == 4'd5) begin
        c = mk(S_WRITEBACK, op);
        c.rwe = 1'b1; c.alu_chk = 1'b1;
        c.alu = arith ? 3'(op - 4'd1) : 3'd4;
        q.push_back(c);
      end
    end
    c = q[q.size() - 1];
    if (!(c.run && (c.step || !STEP_EN))) push_idle();
  endtask

  task automatic apply(input cyc_t c);
    @(negedge Clock);
    Run = c.run; Step = c.step; Mem_Ready = c.rdy; Alu_Zero = c.zero; Opcode = c.op;
    #1;
    check_eq("outs",
             32'({State, Halted, Fault, Mem_Req, Mem_We, Pc_Inc, Pc_Load, Ir_Load, Reg_We, Illegal_Op}),
             32'({c.st, c.st == S_HALT, c.st == S_FAULT, c.req, c.we, c.inc, c.pld, c.ir, c.rwe, c.ill}));
    if (c.alu_chk) check_eq("alu_op", 32'(Alu_Op), 32'(c.alu));
    cyc++;
  endtask

  task automatic run_queue(input int limit);
    int n;
    n = 0;
    while (q.size() > 0 && n < limit) begin
      apply(q.pop_front());
      n++;
    end
    q.delete();
  endtask

  // Two reset cycles with arbitrary inputs, then the all-idle reset state.
  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      Reset = 1'b1; Run = 1'($urandom); Step = 1'($urandom);
      Mem_Ready = 1'($urandom); Alu_Zero = 1'($urandom); Opcode = 4'($urandom);
    end
    @(negedge Clock);
    #1;
    check_eq("reset_outs",
             32'({State, Halted, Fault, Mem_Req, Mem_We, Pc_Inc, Pc_Load, Ir_Load, Reg_We, Illegal_Op}),
             32'd0);
    check_eq("reset_alu", 32'(Alu_Op), 32'd0);
    Reset = 1'b0; Run = 1'b0; Step = 1'b0;
    cyc++;
  endtask

  initial begin
    bit term;
    int lim;
    Reset = 1'b1; Run = 1'b0; Step = 1'b0; Mem_Ready = 1'b0; Alu_Zero = 1'b0; Opcode = 4'd0;
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      push_idle();
      term = 1'b0;
      for (int i = 0; i < 25 && !term; i++) plan_instr(term);
      // Sometimes cut the stream short so reset also lands mid-instruction.
      lim = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, q.size())) : q.size();
      run_queue(lim);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
